huff_pair_collector: RTL and testbench

- Sits directly downstream of the per-table Huffman pair decoders (HT_xx).
- Accepts signed (x,y) pairs from the big_values region of one granule channel, buffers them in a small FIFO, and emits them with a running pair index to the spectrum-sample store.
- After big_values pairs it zero-fills the remaining pair slots up to GRANULE_PAIRS, then pulses done.
- Also provides backpressure (in_ready) for the upstream bit feeder to gate axiiv.

---
 rtl/huff_pair_collector.sv | 148 ++++++++++++++
 tb/tb_huff_pair_collector.sv | 422 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/huff_pair_collector.sv
// Buffers signed (x,y) Huffman pairs of one granule channel in a small FIFO and emits them
// with a contiguous pair index, zero-filling the remaining slots before pulsing done.
module huff_pair_collector #(
    parameter int unsigned GRANULE_PAIRS = 288,
    parameter int unsigned FIFO_DEPTH    = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [8:0]  big_values,
    input  logic        pair_valid,
    input  logic [15:0] x_in,
    input  logic [15:0] y_in,
    output logic        in_ready,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [8:0]  out_index,
    output logic [15:0] out_x,
    output logic [15:0] out_y,
    output logic        done,
    output logic        overflow,
    output logic        busy
);
    localparam int unsigned     PtrW     = $clog2(FIFO_DEPTH);
    localparam int unsigned     CntW     = PtrW + 1;
    localparam logic [8:0]      MaxPairs = 9'(GRANULE_PAIRS);
    localparam logic [8:0]      LastSlot = 9'(GRANULE_PAIRS - 1);
    localparam logic [CntW-1:0] FullCnt  = CntW'(FIFO_DEPTH);

    typedef enum logic [1:0] {StIdle, StCollect, StFill, StDone} state_e;

    state_e            state_q, state_d;
    logic [8:0]        target_q, target_d;
    logic [8:0]        accepted_q, accepted_d;
    logic [8:0]        slot_q, slot_d;
    logic              overflow_q, overflow_d;
    logic              done_q, done_d;
    logic [PtrW-1:0]   wptr_q, wptr_d;
    logic [PtrW-1:0]   rptr_q, rptr_d;
    logic [CntW-1:0]   count_q, count_d;
    logic [31:0]       mem_q [FIFO_DEPTH];
    logic [31:0]       mem_d [FIFO_DEPTH];
    logic              push, pop;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= StIdle;
            target_q   <= '0;
            accepted_q <= '0;
            slot_q     <= '0;
            overflow_q <= 1'b0;
            done_q     <= 1'b0;
            wptr_q     <= '0;
            rptr_q     <= '0;
            count_q    <= '0;
            mem_q      <= '{default: '0};
        end else begin
            state_q    <= state_d;
            target_q   <= target_d;
            accepted_q <= accepted_d;
            slot_q     <= slot_d;
            overflow_q <= overflow_d;
            done_q     <= done_d;
            wptr_q     <= wptr_d;
            rptr_q     <= rptr_d;
            count_q    <= count_d;
            mem_q      <= mem_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        target_d   = target_q;
        accepted_d = accepted_q;
        slot_d     = slot_q;
        overflow_d = overflow_q;
        wptr_d     = wptr_q;
        rptr_d     = rptr_q;
        count_d    = count_q;
        mem_d      = mem_q;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        out_x      = '0;
        out_y      = '0;
        push       = 1'b0;
        pop        = 1'b0;

        case (state_q)
            StIdle, StDone: begin
                if (start) begin
                    target_d   = (big_values > MaxPairs) ? MaxPairs : big_values;
                    accepted_d = '0;
                    slot_d     = '0;
                    overflow_d = 1'b0;
                    wptr_d     = '0;
                    rptr_d     = '0;
                    count_d    = '0;
                    state_d    = (target_d == '0) ? StFill : StCollect;
                end
            end
            StCollect: begin
                // Registered count only: a pop in the same cycle gives no push credit.
                in_ready  = (count_q < FullCnt) && (accepted_q < target_q);
                out_valid = (count_q != '0);
                if (out_valid) begin
                    {out_x, out_y} = mem_q[rptr_q];
                end
                push = pair_valid && in_ready;
                pop  = out_valid && out_ready;
                if (pair_valid && !in_ready) begin
                    overflow_d = 1'b1;
                end
                if (push) begin
                    mem_d[wptr_q] = {x_in, y_in};
                    wptr_d        = wptr_q + PtrW'(1);
                    accepted_d    = accepted_q + 9'd1;
                end
                if (pop) begin
                    rptr_d = rptr_q + PtrW'(1);
                    slot_d = slot_q + 9'd1;
                end
                count_d = count_q + CntW'(push) - CntW'(pop);
                if (pop && slot_q == LastSlot) begin
                    state_d = StDone;
                end else if (accepted_d == target_q && count_d == '0) begin
                    state_d = StFill;
                end
            end
            StFill: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    slot_d = slot_q + 9'd1;
                    if (slot_q == LastSlot) begin
                        state_d = StDone;
                    end
                end
            end
            default: ;
        endcase
    end

    assign done_d    = (state_d == StDone) && (state_q != StDone);
    assign out_index = slot_q;
    assign done      = done_q;
    assign overflow  = overflow_q;
    assign busy      = (state_q == StCollect) || (state_q == StFill);

endmodule

// File: tb/tb_huff_pair_collector.sv
// Randomized bench for huff_pair_collector: a queue-based model predicts the full indexed
// output stream (accepted pairs in order, then zeros) for each granule channel.
module tb_huff_pair_collector;
    localparam int GP    = 288;
    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [8:0]  big_values = '0;
    logic        pair_valid = 1'b0;
    logic [15:0] x_in = '0;
    logic [15:0] y_in = '0;
    logic        out_ready = 1'b0;
    logic        in_ready, out_valid, done, overflow, busy;
    logic [8:0]  out_index;
    logic [15:0] out_x, out_y;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;
    int done_cnt = 0;
    int done_cyc = -1;
    int last_cyc = -1;
    int ir_cnt = 0;
    int stall_err = 0;
    logic [40:0] obs_q[$];
    logic [40:0] exp_q[$];
    logic [31:0] tx_q[$];
    logic [31:0] sent_q[$];

    huff_pair_collector dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .big_values (big_values),
        .pair_valid (pair_valid),
        .x_in       (x_in),
        .y_in       (y_in),
        .in_ready   (in_ready),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_index  (out_index),
        .out_x      (out_x),
        .out_y      (out_y),
        .done       (done),
        .overflow   (overflow),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Record every handshake and done pulse half a cycle before the edge that commits it.
    always @(negedge clk) begin
        if (!rst) begin
            if (out_valid && out_ready) begin
                obs_q.push_back({out_index, out_x, out_y});
                if (out_index == 9'(GP - 1)) last_cyc = cyc;
            end
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
            end
            if (in_ready) ir_cnt++;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_obs();
        obs_q.delete();
        sent_q.delete();
        tx_q.delete();
        done_cnt = 0;
        ir_cnt = 0;
        last_cyc = -1;
        done_cyc = -1;
    endtask

    task automatic do_start(input int bv);
        big_values = 9'(bv);
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    // Valid/ready producer: each pair is held until the collector takes it.
    task automatic produce(input int max_gap);
        logic [31:0] p;
        int k;
        bit got;
        while (tx_q.size() > 0) begin
            p = tx_q.pop_front();
            pair_valid = 1'b1;
            {x_in, y_in} = p;
            got = 0;
            k = 0;
            while (!got && k < 400) begin
                @(negedge clk);
                if (in_ready) got = 1;
                else begin
                    k++;
                    tick();
                end
            end
            if (!got) begin
                n_cmp++;
                n_bad++;
                $display("FAIL produce_timeout: pair %h never accepted, want accepted", p);
                pair_valid = 1'b0;
                return;
            end
            sent_q.push_back(p);
            tick();
            pair_valid = 1'b0;
            if (max_gap > 0) repeat ($urandom_range(max_gap, 0)) tick();
        end
    endtask

    task automatic wait_done(input int budget);
        int k = 0;
        while (done_cnt == 0 && k < budget) begin
            tick();
            k++;
        end
        n_cmp++;
        if (done_cnt == 0) begin
            n_bad++;
            $display("FAIL done_timeout: got no done in %0d cycles, want one", budget);
        end
        repeat (3) tick();
    endtask

    task automatic consume_random(input int budget);
        logic        held_v = 1'b0;
        logic [40:0] held = '0;
        for (int k = 0; k < budget && done_cnt == 0; k++) begin
            out_ready = 1'($urandom_range(1, 0));
            @(negedge clk);
            if (held_v && !(out_valid && {out_index, out_x, out_y} == held)) stall_err++;
            held_v = out_valid && !out_ready;
            held = {out_index, out_x, out_y};
            tick();
        end
        out_ready = 1'b1;
    endtask

    // Reference: slot i carries the i-th accepted pair while i < target, otherwise zeros.
    function automatic void build_exp(input int bv);
        int tgt = (bv > GP) ? GP : bv;
        exp_q.delete();
        for (int i = 0; i < GP; i++) begin
            exp_q.push_back({9'(i), (i < tgt && i < sent_q.size()) ? sent_q[i] : 32'h0});
        end
    endfunction

    function automatic int first_diff();
        int n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) if (obs_q[i] !== exp_q[i]) return i;
        if (obs_q.size() != exp_q.size()) return n;
        return -1;
    endfunction

    function automatic logic [40:0] obs_el(input int i);
        return (i >= 0 && i < obs_q.size()) ? obs_q[i] : 41'h0;
    endfunction

    function automatic logic [40:0] exp_el(input int i);
        return (i >= 0 && i < exp_q.size()) ? exp_q[i] : 41'h0;
    endfunction

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) tick();
        n_cmp++;
        if ({in_ready, out_valid, out_index, out_x, out_y, done, overflow, busy} !== '0) begin
            n_bad++;
            $display("FAIL reset_outputs: got rdy=%b v=%b idx=%0d x=%h y=%h d=%b ov=%b b=%b, want all 0",
                     in_ready, out_valid, out_index, out_x, out_y, done, overflow, busy);
        end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_basic();
        int d;
        clear_obs();
        out_ready = 1'b1;
        tx_q.push_back(32'h0001_FFFE);
        tx_q.push_back(32'h0000_0000);
        tx_q.push_back(32'hFFF1_0007);
        do_start(3);
        fork
            produce(0);
            wait_done(1000);
        join
        build_exp(3);
        d = first_diff();
        n_cmp++;
        if (d != -1) begin
            n_bad++;
            $display("FAIL basic_stream[%0d]: got %h want %h (%0d xfers, want %0d)",
                     d, obs_el(d), exp_el(d), obs_q.size(), exp_q.size());
        end
        n_cmp++;
        if (overflow !== 1'b0) begin
            n_bad++;
            $display("FAIL basic_overflow: got %b want 0", overflow);
        end
        n_cmp++;
        if (done_cnt != 1) begin
            n_bad++;
            $display("FAIL basic_done_count: got %0d want 1", done_cnt);
        end
        n_cmp++;
        if (done_cyc != last_cyc + 1) begin
            n_bad++;
            $display("FAIL basic_done_timing: got cycle %0d want %0d", done_cyc, last_cyc + 1);
        end
    endtask

    task automatic test_zero();
        int d;
        clear_obs();
        out_ready = 1'b1;
        do_start(0);
        wait_done(1000);
        build_exp(0);
        d = first_diff();
        n_cmp++;
        if (d != -1) begin
            n_bad++;
            $display("FAIL zero_stream[%0d]: got %h want %h (%0d xfers, want %0d)",
                     d, obs_el(d), exp_el(d), obs_q.size(), exp_q.size());
        end
        n_cmp++;
        if (ir_cnt != 0) begin
            n_bad++;
            $display("FAIL zero_in_ready: got %0d ready cycles want 0", ir_cnt);
        end
        n_cmp++;
        if (done_cnt != 1) begin
            n_bad++;
            $display("FAIL zero_done_count: got %0d want 1", done_cnt);
        end
    endtask

    task automatic test_backpressure();
        logic [31:0] p;
        int d;
        clear_obs();
        out_ready = 1'b0;
        do_start(8);
        for (int i = 0; i < 8; i++) begin
            p = $urandom;
            pair_valid = 1'b1;
            {x_in, y_in} = p;
            if (i < DEPTH) sent_q.push_back(p);
            @(negedge clk);
            if (i == DEPTH) begin
                n_cmp++;
                if (in_ready !== 1'b0) begin
                    n_bad++;
                    $display("FAIL bp_in_ready_full: got %b want 0", in_ready);
                end
            end
            tick();
        end
        pair_valid = 1'b0;
        n_cmp++;
        if (overflow !== 1'b1) begin
            n_bad++;
            $display("FAIL bp_overflow: got %b want 1", overflow);
        end
        // Dropped pairs never count toward the target, so upstream supplies four more.
        for (int i = 0; i < 4; i++) tx_q.push_back($urandom);
        out_ready = 1'b1;
        fork
            produce(1);
            wait_done(1500);
        join
        build_exp(8);
        d = first_diff();
        n_cmp++;
        if (d != -1) begin
            n_bad++;
            $display("FAIL bp_stream[%0d]: got %h want %h (%0d xfers, want %0d)",
                     d, obs_el(d), exp_el(d), obs_q.size(), exp_q.size());
        end
    endtask

    task automatic test_clamp();
        int d;
        clear_obs();
        out_ready = 1'b1;
        for (int i = 0; i < GP; i++) tx_q.push_back($urandom);
        do_start(400);
        produce(0);
        pair_valid = 1'b1;
        {x_in, y_in} = $urandom;
        @(negedge clk);
        n_cmp++;
        if (in_ready !== 1'b0) begin
            n_bad++;
            $display("FAIL clamp_in_ready: got %b want 0", in_ready);
        end
        tick();
        pair_valid = 1'b0;
        n_cmp++;
        if (overflow !== 1'b1) begin
            n_bad++;
            $display("FAIL clamp_overflow: got %b want 1", overflow);
        end
        wait_done(1000);
        build_exp(400);
        d = first_diff();
        n_cmp++;
        if (d != -1) begin
            n_bad++;
            $display("FAIL clamp_stream[%0d]: got %h want %h (%0d xfers, want %0d)",
                     d, obs_el(d), exp_el(d), obs_q.size(), exp_q.size());
        end
    endtask

    task automatic test_random_stalls();
        int d;
        clear_obs();
        stall_err = 0;
        for (int i = 0; i < 10; i++) tx_q.push_back($urandom);
        do_start(10);
        fork
            produce(3);
            consume_random(4000);
        join
        wait_done(100);
        build_exp(10);
        d = first_diff();
        n_cmp++;
        if (d != -1) begin
            n_bad++;
            $display("FAIL stall_stream[%0d]: got %h want %h (%0d xfers, want %0d)",
                     d, obs_el(d), exp_el(d), obs_q.size(), exp_q.size());
        end
        n_cmp++;
        if (stall_err != 0) begin
            n_bad++;
            $display("FAIL stall_hold: got %0d unstable stalled cycles want 0", stall_err);
        end
        n_cmp++;
        if (overflow !== 1'b0) begin
            n_bad++;
            $display("FAIL stall_overflow: got %b want 0", overflow);
        end
    endtask

    task automatic test_reset_mid();
        int  d;
        int  k = 0;
        bit  hit = 0;
        clear_obs();
        out_ready = 1'b1;
        do_start(0);
        while (!hit && k < 500) begin
            @(negedge clk);
            if (out_valid && out_index == 9'd100) hit = 1;
            else begin
                k++;
                tick();
            end
        end
        n_cmp++;
        if (!hit) begin
            n_bad++;
            $display("FAIL mid_reach_idx100: got idx %0d want 100", out_index);
        end
        #1 rst = 1'b1;
        #1;
        n_cmp++;
        if ({in_ready, out_valid, out_index, out_x, out_y, done, overflow, busy} !== '0) begin
            n_bad++;
            $display("FAIL mid_reset_outputs: got v=%b idx=%0d b=%b, want all 0",
                     out_valid, out_index, busy);
        end
        tick();
        rst = 1'b0;
        tick();
        clear_obs();
        tx_q.push_back($urandom);
        tx_q.push_back($urandom);
        do_start(2);
        fork
            produce(2);
            wait_done(1000);
        join
        build_exp(2);
        d = first_diff();
        n_cmp++;
        if (d != -1) begin
            n_bad++;
            $display("FAIL mid_restart_stream[%0d]: got %h want %h (%0d xfers, want %0d)",
                     d, obs_el(d), exp_el(d), obs_q.size(), exp_q.size());
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_zero();
        test_backpressure();
        test_clamp();
        test_random_stalls();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
